// File: rtl/fabric_config_source_arbiter.sv
// Bitstream source arbiter: synchronises the mode pad, latches the active
// source, issues start pulses to controller-type sources, forwards the active
// source's words to fabric_config with one cycle of latency, counts words and
// aborts stalled loads with a timeout.
module fabric_config_source_arbiter #(
  parameter int                     NUM_SOURCES     = 2,
  parameter int                     DATA_WIDTH      = 32,
  parameter int                     SLOT_WIDTH      = 4,
  parameter int                     SYNC_STAGES     = 2,
  parameter logic [NUM_SOURCES-1:0] CONTROLLER_MASK = 'b01,
  parameter int unsigned            TIMEOUT_CYCLES  = 65535,
  localparam int                    SRC_W           = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [SRC_W-1:0]                  mode_i,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] src_data_i,
  input  logic [NUM_SOURCES-1:0]            src_valid_i,
  output logic [NUM_SOURCES-1:0]            src_enable_o,
  output logic                              start_o,
  output logic [SLOT_WIDTH-1:0]             slot_o,
  input  logic                              ctrl_busy_i,
  input  logic                              config_busy_i,
  input  logic                              warmboot_boot_i,
  input  logic [SLOT_WIDTH-1:0]             warmboot_slot_i,
  output logic [DATA_WIDTH-1:0]             bitstream_data_o,
  output logic                              bitstream_valid_o,
  output logic [SRC_W-1:0]                  active_src_o,
  output logic [31:0]                       word_count_o,
  output logic                              busy_o,
  output logic                              timeout_o
);

  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [1:0] {BOOT, IDLE, LOAD, ERROR} state_t;

  state_t                  state, state_next;
  logic [SRC_W-1:0]        sync_q [SYNC_N];
  logic [SRC_W-1:0]        mode_sync, mode_sel, cur_src;
  logic [DATA_WIDTH-1:0]   sel_data_p0;
  logic                    sel_vld_p0, sel_ctrl;
  logic [NUM_SOURCES-1:0]  onehot_sel;
  logic                    wb_ok, fwd, start_go, clr_count, set_tmo, clr_tmo, tmo_hit;
  logic [SLOT_WIDTH-1:0]   slot_next;
  logic [31:0]             tcnt, tcnt_inc;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  // Out-of-range mode requests fall back to source 0. The source is frozen
  // during a load; elsewhere the freshly synchronised request is used so the
  // decision made this cycle matches the source being latched.
  assign mode_sync = sync_q[SYNC_N-1];
  assign mode_sel  = (int'(mode_sync) >= NUM_SOURCES) ? '0 : mode_sync;
  assign cur_src   = (state == LOAD) ? active_src_o : mode_sel;

  // Mode pad synchroniser; BOOT therefore always sees its reset value (source 0).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_N; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= mode_i;
      for (int i = 1; i < SYNC_N; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Stage p0: pick the word, valid and controller flag of the current source.
  always_comb begin
    sel_data_p0 = '0;
    sel_vld_p0  = 1'b0;
    sel_ctrl    = 1'b0;
    onehot_sel  = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (cur_src == SRC_W'(i)) begin
        sel_data_p0 = src_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        sel_vld_p0  = src_valid_i[i];
        sel_ctrl    = CONTROLLER_MASK[i];
      end
      onehot_sel[i] = (mode_sel == SRC_W'(i));
    end
  end

  // Next-state and per-cycle control decisions.
  always_comb begin
    state_next = state;
    fwd        = 1'b0;
    start_go   = 1'b0;
    slot_next  = '0;
    clr_count  = 1'b0;
    set_tmo    = 1'b0;
    clr_tmo    = 1'b0;
    wb_ok      = warmboot_boot_i && !config_busy_i && !ctrl_busy_i;
    tcnt_inc   = tcnt + 32'd1;
    tmo_hit    = (TIMEOUT_CYCLES != 0) && (tcnt_inc == TIMEOUT_CYCLES);
    case (state)
      BOOT: begin
        if (sel_ctrl) begin
          start_go   = 1'b1;
          clr_count  = 1'b1;
          state_next = LOAD;
        end else begin
          state_next = IDLE;
        end
      end
      IDLE: begin
        if (sel_ctrl) begin
          if (wb_ok) begin
            start_go   = 1'b1;
            slot_next  = warmboot_slot_i;
            clr_count  = 1'b1;
            state_next = LOAD;
          end
        end else if (sel_vld_p0) begin
          fwd        = 1'b1;
          clr_count  = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (sel_vld_p0) begin
          fwd = 1'b1;
        end else if ((word_count_o != 32'd0) && !ctrl_busy_i && !config_busy_i) begin
          state_next = IDLE;
        end else if (tmo_hit) begin
          set_tmo    = 1'b1;
          state_next = ERROR;
        end
      end
      ERROR: begin
        if (sel_ctrl && wb_ok) begin
          start_go   = 1'b1;
          slot_next  = warmboot_slot_i;
          clr_count  = 1'b1;
          clr_tmo    = 1'b1;
          state_next = LOAD;
        end
      end
      default: state_next = BOOT;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= BOOT;
    else         state <= state_next;
  end

  // Control outputs: source latch, start/slot pulse, busy and sticky timeout.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_src_o <= '0;
      src_enable_o <= '0;
      start_o      <= 1'b0;
      slot_o       <= '0;
      busy_o       <= 1'b0;
      timeout_o    <= 1'b0;
    end else begin
      if (state != LOAD) begin
        active_src_o <= mode_sel;
        src_enable_o <= onehot_sel;
      end
      start_o <= start_go;
      slot_o  <= slot_next;
      busy_o  <= (state_next == LOAD) || (state_next == BOOT);
      if (set_tmo)      timeout_o <= 1'b1;
      else if (clr_tmo) timeout_o <= 1'b0;
    end
  end

  // Idle-cycle counter: held at zero outside LOAD and on each forwarded word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                       tcnt <= '0;
    else if (state != LOAD || fwd)     tcnt <= '0;
    else if (TIMEOUT_CYCLES != 0)      tcnt <= tcnt_inc;
  end

  // Stage p1: registered word, valid and saturating word count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bitstream_data_o  <= '0;
      bitstream_valid_o <= 1'b0;
      word_count_o      <= '0;
    end else begin
      bitstream_valid_o <= fwd;
      if (fwd) bitstream_data_o <= sel_data_p0;
      if (clr_count) word_count_o <= {31'd0, fwd};
      else if (fwd)  word_count_o <= sat_inc(word_count_o);
    end
  end

endmodule

// File: tb/tb_fabric_config_source_arbiter.sv
// Directed bench for fabric_config_source_arbiter: three sources, source 0 a
// controller, sources 1 and 2 receivers, 16-cycle load timeout.
module tb_fabric_config_source_arbiter;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic [1:0]    mode_i;
  logic [N*DW-1:0] src_data_i;
  logic [N-1:0]  src_valid_i;
  logic [N-1:0]  src_enable_o;
  logic          start_o;
  logic [SW-1:0] slot_o;
  logic          ctrl_busy_i, config_busy_i, warmboot_boot_i;
  logic [SW-1:0] warmboot_slot_i;
  logic [DW-1:0] bitstream_data_o;
  logic          bitstream_valid_o;
  logic [1:0]    active_src_o;
  logic [31:0]   word_count_o;
  logic          busy_o, timeout_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fabric_config_source_arbiter #(
    .NUM_SOURCES(N), .DATA_WIDTH(DW), .SLOT_WIDTH(SW), .SYNC_STAGES(2),
    .CONTROLLER_MASK(3'b001), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .mode_i(mode_i),
    .src_data_i(src_data_i), .src_valid_i(src_valid_i),
    .src_enable_o(src_enable_o), .start_o(start_o), .slot_o(slot_o),
    .ctrl_busy_i(ctrl_busy_i), .config_busy_i(config_busy_i),
    .warmboot_boot_i(warmboot_boot_i), .warmboot_slot_i(warmboot_slot_i),
    .bitstream_data_o(bitstream_data_o), .bitstream_valid_o(bitstream_valid_o),
    .active_src_o(active_src_o), .word_count_o(word_count_o),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; mode_i = 2'd0; src_data_i = '0; src_valid_i = '0;
    ctrl_busy_i = 1'b1; config_busy_i = 1'b1; warmboot_boot_i = 1'b0; warmboot_slot_i = '0;
    repeat (3) tick();
    total++; if ({src_enable_o, start_o, slot_o, bitstream_data_o, bitstream_valid_o, active_src_o, word_count_o, busy_o, timeout_o} !== '0) begin
      bad++; $display("FAIL reset_outputs: got en=%b st=%b slot=%h d=%h v=%b src=%0d cnt=%0d busy=%b to=%b want all 0",
        src_enable_o, start_o, slot_o, bitstream_data_o, bitstream_valid_o, active_src_o, word_count_o, busy_o, timeout_o); end
    rst_ni = 1'b1;
    tick();
    total++; if ({start_o, slot_o, busy_o, src_enable_o} !== {1'b1, 4'd0, 1'b1, 3'b001}) begin
      bad++; $display("FAIL boot_start: got start=%b slot=%0d busy=%b en=%b want 1 0 1 001", start_o, slot_o, busy_o, src_enable_o); end
    tick();
    total++; if (start_o !== 1'b0) begin bad++; $display("FAIL boot_single_pulse: got %b want 0", start_o); end
  endtask

  task automatic test_controller_load();
    logic [31:0] words [4] = '{32'hA5A5_0001, 32'h0F0F_0002, 32'hCAFE_0003, 32'h1234_0004};
    for (int k = 0; k < 4; k++) begin
      src_valid_i = 3'b001;
      src_data_i[31:0]  = words[k];
      src_data_i[63:32] = 32'hBAD0_0000 + k;
      tick();
      total++; if ({bitstream_valid_o, bitstream_data_o, word_count_o} !== {1'b1, words[k], 32'(k + 1)}) begin
        bad++; $display("FAIL ctrl_word%0d: got v=%b d=%h cnt=%0d want 1 %h %0d", k, bitstream_valid_o, bitstream_data_o, word_count_o, words[k], k + 1); end
    end
    src_valid_i = '0; ctrl_busy_i = 1'b0; config_busy_i = 1'b0;
    tick();
    total++; if ({busy_o, bitstream_valid_o, word_count_o} !== {1'b0, 1'b0, 32'd4}) begin
      bad++; $display("FAIL ctrl_done: got busy=%b v=%b cnt=%0d want 0 0 4", busy_o, bitstream_valid_o, word_count_o); end
  endtask

  task automatic test_warmboot();
    warmboot_boot_i = 1'b1; warmboot_slot_i = 4'd5; config_busy_i = 1'b1;
    tick(); tick();
    total++; if ({start_o, busy_o} !== 2'b00) begin bad++; $display("FAIL wb_blocked: got start=%b busy=%b want 0 0", start_o, busy_o); end
    config_busy_i = 1'b0;
    tick();
    total++; if ({start_o, slot_o, busy_o, word_count_o} !== {1'b1, 4'd5, 1'b1, 32'd0}) begin
      bad++; $display("FAIL wb_start: got start=%b slot=%0d busy=%b cnt=%0d want 1 5 1 0", start_o, slot_o, busy_o, word_count_o); end
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if ({start_o, busy_o} !== 2'b01) begin bad++; $display("FAIL wb_no_repeat%0d: got start=%b busy=%b want 0 1", k, start_o, busy_o); end
    end
    warmboot_boot_i = 1'b0; src_valid_i = 3'b001; src_data_i[31:0] = 32'h5151_AAAA;
    tick();
    total++; if ({bitstream_valid_o, bitstream_data_o, word_count_o} !== {1'b1, 32'h5151_AAAA, 32'd1}) begin
      bad++; $display("FAIL wb_word: got v=%b d=%h cnt=%0d want 1 5151aaaa 1", bitstream_valid_o, bitstream_data_o, word_count_o); end
    src_valid_i = '0;
    tick();
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL wb_done: got busy=%b want 0", busy_o); end
  endtask

  task automatic test_timeout();
    warmboot_boot_i = 1'b1; warmboot_slot_i = 4'd3;
    tick();
    total++; if ({start_o, slot_o} !== {1'b1, 4'd3}) begin bad++; $display("FAIL to_start: got start=%b slot=%0d want 1 3", start_o, slot_o); end
    warmboot_boot_i = 1'b0;
    repeat (15) tick();
    total++; if ({timeout_o, busy_o} !== 2'b01) begin bad++; $display("FAIL to_early: got to=%b busy=%b want 0 1", timeout_o, busy_o); end
    tick();
    total++; if ({timeout_o, busy_o} !== 2'b10) begin bad++; $display("FAIL to_hit: got to=%b busy=%b want 1 0", timeout_o, busy_o); end
    src_valid_i = 3'b001; src_data_i[31:0] = 32'hDEAD_0BAD;
    tick();
    total++; if ({bitstream_valid_o, word_count_o, timeout_o} !== {1'b0, 32'd0, 1'b1}) begin
      bad++; $display("FAIL to_drop: got v=%b cnt=%0d to=%b want 0 0 1", bitstream_valid_o, word_count_o, timeout_o); end
    src_valid_i = '0; warmboot_boot_i = 1'b1; warmboot_slot_i = 4'd9;
    tick();
    total++; if ({start_o, slot_o, timeout_o, busy_o} !== {1'b1, 4'd9, 1'b0, 1'b1}) begin
      bad++; $display("FAIL to_restart: got start=%b slot=%0d to=%b busy=%b want 1 9 0 1", start_o, slot_o, timeout_o, busy_o); end
    warmboot_boot_i = 1'b0; src_valid_i = 3'b001; src_data_i[31:0] = 32'h0000_7777;
    tick();
    total++; if ({bitstream_valid_o, bitstream_data_o} !== {1'b1, 32'h0000_7777}) begin
      bad++; $display("FAIL to_reload_word: got v=%b d=%h want 1 00007777", bitstream_valid_o, bitstream_data_o); end
    src_valid_i = '0;
    tick();
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL to_reload_done: got busy=%b want 0", busy_o); end
  endtask

  task automatic test_mode_switch();
    warmboot_boot_i = 1'b1; warmboot_slot_i = 4'd1;
    tick();
    warmboot_boot_i = 1'b0; ctrl_busy_i = 1'b1; mode_i = 2'd1;
    src_valid_i = 3'b001; src_data_i[31:0] = 32'h4242_4242;
    tick();
    src_valid_i = '0;
    repeat (4) tick();
    total++; if ({active_src_o, src_enable_o, busy_o} !== {2'd0, 3'b001, 1'b1}) begin
      bad++; $display("FAIL mode_frozen: got src=%0d en=%b busy=%b want 0 001 1", active_src_o, src_enable_o, busy_o); end
    ctrl_busy_i = 1'b0;
    tick();
    total++; if ({active_src_o, busy_o} !== {2'd0, 1'b0}) begin
      bad++; $display("FAIL mode_exit: got src=%0d busy=%b want 0 0", active_src_o, busy_o); end
    tick();
    total++; if ({active_src_o, src_enable_o, start_o} !== {2'd1, 3'b010, 1'b0}) begin
      bad++; $display("FAIL mode_switch: got src=%0d en=%b start=%b want 1 010 0", active_src_o, src_enable_o, start_o); end
  endtask

  task automatic test_receiver();
    src_valid_i = 3'b011; src_data_i[31:0] = 32'hAAAA_5555; src_data_i[63:32] = 32'hDEAD_BEEF;
    tick();
    total++; if ({bitstream_valid_o, bitstream_data_o, word_count_o, start_o} !== {1'b1, 32'hDEAD_BEEF, 32'd1, 1'b0}) begin
      bad++; $display("FAIL rx_word0: got v=%b d=%h cnt=%0d start=%b want 1 deadbeef 1 0", bitstream_valid_o, bitstream_data_o, word_count_o, start_o); end
    src_data_i[31:0] = 32'h1111_1111; src_data_i[63:32] = 32'h1234_5678;
    tick();
    total++; if ({bitstream_valid_o, bitstream_data_o, word_count_o} !== {1'b1, 32'h1234_5678, 32'd2}) begin
      bad++; $display("FAIL rx_word1: got v=%b d=%h cnt=%0d want 1 12345678 2", bitstream_valid_o, bitstream_data_o, word_count_o); end
    src_valid_i = 3'b001;
    tick();
    total++; if ({bitstream_valid_o, word_count_o, busy_o} !== {1'b0, 32'd2, 1'b0}) begin
      bad++; $display("FAIL rx_ignore_src0: got v=%b cnt=%0d busy=%b want 0 2 0", bitstream_valid_o, word_count_o, busy_o); end
    tick();
    total++; if ({bitstream_valid_o, busy_o, start_o} !== 3'b000) begin
      bad++; $display("FAIL rx_idle_src0: got v=%b busy=%b start=%b want 0 0 0", bitstream_valid_o, busy_o, start_o); end
    src_valid_i = '0;
  endtask

  task automatic test_mode_out_of_range();
    mode_i = 2'd3;
    tick(); tick();
    total++; if (active_src_o !== 2'd1) begin bad++; $display("FAIL mode3_latency: got src=%0d want 1", active_src_o); end
    tick();
    total++; if ({active_src_o, src_enable_o} !== {2'd0, 3'b001}) begin
      bad++; $display("FAIL mode3_map: got src=%0d en=%b want 0 001", active_src_o, src_enable_o); end
    mode_i = 2'd0;
  endtask

  task automatic test_reset_midload();
    warmboot_boot_i = 1'b1; warmboot_slot_i = 4'd2;
    tick();
    warmboot_boot_i = 1'b0; ctrl_busy_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      src_valid_i = 3'b001; src_data_i[31:0] = 32'h0000_0100 + k;
      tick();
    end
    src_valid_i = '0;
    total++; if ({word_count_o, busy_o} !== {32'd3, 1'b1}) begin
      bad++; $display("FAIL midload_count: got cnt=%0d busy=%b want 3 1", word_count_o, busy_o); end
    #1 rst_ni = 1'b0;
    #1;
    total++; if ({src_enable_o, start_o, slot_o, bitstream_data_o, bitstream_valid_o, active_src_o, word_count_o, busy_o, timeout_o} !== '0) begin
      bad++; $display("FAIL midload_reset: got en=%b st=%b cnt=%0d busy=%b d=%h want all 0", src_enable_o, start_o, word_count_o, busy_o, bitstream_data_o); end
    tick();
    rst_ni = 1'b1;
    tick();
    total++; if ({start_o, slot_o, busy_o, word_count_o} !== {1'b1, 4'd0, 1'b1, 32'd0}) begin
      bad++; $display("FAIL reboot_start: got start=%b slot=%0d busy=%b cnt=%0d want 1 0 1 0", start_o, slot_o, busy_o, word_count_o); end
    tick();
    total++; if (start_o !== 1'b0) begin bad++; $display("FAIL reboot_single_pulse: got %b want 0", start_o); end
  endtask

  initial begin
    test_reset();
    test_controller_load();
    test_warmboot();
    test_timeout();
    test_mode_switch();
    test_receiver();
    test_mode_out_of_range();
    test_reset_midload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fabric_config_source_arbiter.md
Name: fabric_config_source_arbiter

Overview:
- Parametrised successor to the fixed two-way SPI controller/receiver bitstream mux used at chip-core level.
- Selects one of NUM_SOURCES bitstream sources using a synchronised mode input, and routes its word stream to fabric_config.
- Generates startup and warmboot start pulses for controller-type sources, counts words, and aborts stalled loads with a timeout.
- Sits between the SPI source blocks and fabric_config.

Parameters:
- NUM_SOURCES, 2: number of bitstream sources. The source index width SRC_W = max(1, $clog2(NUM_SOURCES)).
- DATA_WIDTH, 32: bitstream word width.
- SLOT_WIDTH, 4: warmboot slot width.
- SYNC_STAGES, 2: synchroniser depth for mode_i (minimum 2).
- CONTROLLER_MASK, 'b01: bit i = 1 means source i is an active controller (needs start/slot); bit i = 0 means a passive receiver.
- TIMEOUT_CYCLES, 65535: idle cycles tolerated inside a load. 0 disables the timeout.

Ports:
- clk_i, in, 1: clock.
- rst_ni, in, 1: reset, asynchronous, active-low.
- mode_i, in, SRC_W: requested source, asynchronous pad input.
- src_data_i, in, NUM_SOURCES*DATA_WIDTH: packed source words; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- src_valid_i, in, NUM_SOURCES: per-source word valid.
- src_enable_o, out, NUM_SOURCES: one-hot enable of the active source.
- start_o, out, 1: single-cycle start pulse to the active controller.
- slot_o, out, SLOT_WIDTH: slot qualified by start_o.
- ctrl_busy_i, in, 1: active controller is reading.
- config_busy_i, in, 1: fabric_config is busy.
- warmboot_boot_i, in, 1: fabric warmboot request (level).
- warmboot_slot_i, in, SLOT_WIDTH: requested slot.
- bitstream_data_o, out, DATA_WIDTH: routed word.
- bitstream_valid_o, out, 1: routed valid.
- active_src_o, out, SRC_W: latched source index.
- word_count_o, out, 32: words forwarded in the current or last load.
- busy_o, out, 1: high in states BOOT and LOAD.
- timeout_o, out, 1: sticky load-abort flag.

Behaviour:
- Reset values: all outputs 0, state BOOT, synchroniser flops 0.
- mode_i passes through SYNC_STAGES flops to give mode_sync. A mode_sync value ≥ NUM_SOURCES is treated as 0.
- active_src_o is loaded from mode_sync only in BOOT, IDLE and ERROR. It is frozen in LOAD, so a mode change during a load takes effect on the first IDLE cycle.
- src_enable_o is registered, equals onehot(active_src_o), and is updated on the same edge as active_src_o.

State BOOT (first cycle after reset release):
- Latch the source.
- If the source is a controller: start_o = 1, slot_o = 0, go to LOAD.
- Otherwise go to IDLE.

State IDLE:
- Controller source: if warmboot_boot_i && !config_busy_i && !ctrl_busy_i, then start_o = 1, slot_o = warmboot_slot_i, clear word_count_o, go to LOAD.
- Receiver source: the first src_valid_i of the active source clears word_count_o, forwards that word, and goes to LOAD.

State LOAD:
- Each valid from the active source is forwarded and word_count_o increments, saturating at 2^32-1.
- Exit to IDLE when all of the following hold: word_count_o > 0, !ctrl_busy_i, !config_busy_i, and no active valid in that cycle.
- warmboot_boot_i is ignored here; it is not queued.

Timeout:
- Counter clears on entry to LOAD and on every forwarded word, and increments otherwise.
- When TIMEOUT_CYCLES ≠ 0 and the counter reaches TIMEOUT_CYCLES: go to ERROR and set timeout_o = 1.
- Valids that arrive after this point are dropped.

State ERROR:
- bitstream_valid_o is forced to 0 and source tracking continues.
- A qualified warmboot request (same conditions as IDLE, controller source) clears timeout_o, pulses start_o and enters LOAD.
- For a receiver source, timeout_o stays set until reset.

Datapath and general rules:
- Data/valid latency is 1 cycle: output registered from the source currently selected.
- Valids from inactive sources are ignored.
- start_o is exactly one cycle wide and never asserted in two consecutive cycles.
- Asynchronous reset mid-load returns to BOOT; all counters and flags clear.

Test Plan:
- Reset release, mode_i = 0 (controller): start_o pulses in the first post-reset cycle with slot_o = 0. Feed 4 valids and drop the busy inputs → word_count_o = 4, each word appears on bitstream_data_o 1 cycle later, state returns to IDLE, busy_o = 0.
- mode_i = 1 (receiver), NUM_SOURCES = 2: no start_o. Source 1 sends 0xDEADBEEF and 0x12345678 → both forwarded in order. Simultaneous valids on source 0 are ignored. word_count_o = 2.
- In IDLE, controller source: warmboot_boot_i = 1, slot 5, config_busy_i = 1 → no start. Release config_busy_i → start_o pulses once with slot_o = 5. Holding warmboot_boot_i during LOAD produces no second pulse.
- TIMEOUT_CYCLES = 16, controller starts and sends no valid → timeout_o = 1 at cycle 16 after start, later valids dropped. A qualified warmboot then clears timeout_o and restarts the load.
- Toggle mode_i 0→1 mid-LOAD → active_src_o and src_enable_o remain 0 / 'b01 until IDLE, then become 1 / 'b10 after SYNC_STAGES + 1 cycles. mode_i = 3 with NUM_SOURCES = 3 → active source 0.
- Assert rst_ni mid-load after 3 words → all outputs 0 immediately. On release, BOOT is re-entered and start_o pulses again.
